imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the fetch stage reads.
- Accepts a framed byte stream (valid/ready), assembles 32-bit big-endian words, and writes them to consecutive instruction-memory word addresses starting at 0.
- Holds the pipeline in reset (cpu_hold) until a frame loads and its checksum matches; then releases it.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  drive to the pipeline reset (OR with reset at top level).
- busy  output  1  load in progress.
- done  output  1  last load completed with a good checksum (level).
- err  output  1  last load failed (level).
- words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset values (async, immediate): state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, words_loaded=0. Memory contents are not touched.
- Frame format:
  - LEN_HI byte, then LEN_LO byte: N = 16-bit word count.
  - N words, 4 bytes each, MSB first.
  - One checksum byte = XOR of every preceding frame byte, including both length bytes.
- States: IDLE, LEN_HI, LEN_LO, WORD, CKSUM, DONE, ERROR.
- A byte is accepted only on a cycle with in_valid && in_ready. in_ready=1 exactly in LEN_HI, LEN_LO, WORD and CKSUM. in_data is ignored otherwise.
- Transitions:
  - IDLE/DONE/ERROR --start--> LEN_HI. Clears done, err and words_loaded; sets busy=1 and cpu_hold=1; resets the running XOR to 0 and the byte index to 0.
  - start is ignored while busy.
  - LEN_HI --accept--> LEN_LO.
  - LEN_LO --accept--> ERROR if N > DEPTH; CKSUM if N == 0; else WORD.
  - WORD: accepts 4 bytes into a shift register.
    - On the 4th accept, the next cycle has imem_we=1, imem_addr=words_loaded[ADDR_W-1:0] (pre-increment) and imem_wdata=assembled word, then words_loaded increments.
    - Write latency is 1 cycle after the 4th byte; imem_we is high for exactly 1 cycle per word.
    - Once words_loaded == N, go to CKSUM. in_ready may stay high during the write cycle; back-to-back bytes every cycle must be sustainable with no lost data.
  - CKSUM --accept--> DONE if byte == running XOR, else ERROR.
  - DONE: busy=0, done=1, cpu_hold=0.
  - ERROR: busy=0, err=1, cpu_hold stays 1.
- The running XOR updates on every accepted byte except the checksum byte itself.
- Words already written before an ERROR remain in memory; the pipeline stays held.
- in_valid gaps (valid low) at any point stall the FSM indefinitely with no timeout.
- Reset mid-load: immediate return to the reset values. No write strobe is issued for a partially assembled word.
- start coincident with an accepted byte in DONE/ERROR: start wins. No byte is accepted in those states.
- N == DEPTH is legal: addresses 0..DEPTH-1 are written with no wrap. words_loaded reaches DEPTH, hence the ADDR_W+1 width.
- All outputs are registered. No combinational path from in_valid to in_ready.

Test Plan:
- One word, contiguous: start; bytes 00 01 20 01 00 05 25 -> one imem_we pulse with addr 0, wdata 0x20010005; then done=1, err=0, cpu_hold=0, words_loaded=1.
- Bad checksum: same frame with last byte 0x24 -> the write to addr 0 still occurs; then err=1, done=0, cpu_hold=1.
- Zero length: bytes 00 00 00 -> no imem_we; done=1, words_loaded=0, cpu_hold=0.
- Oversize: ADDR_W=8, bytes 01 01 (N=257) -> ERROR directly after LEN_LO; no writes; in_ready=0 afterwards.
- Three words with random valid gaps and continuous valid runs -> writes to addr 0,1,2 in order with correct big-endian data; no dropped or duplicated bytes.
- Reset after 2 bytes of word 1 -> all outputs return to reset values with no imem_we. A new start with a full good frame then succeeds and done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed, XOR-checked byte
// frame, writes big-endian 32-bit words from address 0, and holds the CPU until it succeeds.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_CKSUM, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  xor_acc;
  logic [23:0] shift;
  logic [1:0]  byte_idx;

  logic        accept;
  logic        can_start;
  logic        last_byte;
  logic        last_word;
  logic [15:0] len_rx;
  logic        active_next;

  assign accept    = in_valid && in_ready;
  assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign last_byte = (byte_idx == 2'd3);
  assign len_rx    = {len_hi, in_data};
  // Words already committed equal words_loaded here: each write finishes long before the
  // next word's fourth byte can arrive.
  assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, len};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_rx} > DEPTH)  state_next = S_ERROR;
          else if (len_rx == 16'd0)    state_next = S_CKSUM;
          else                         state_next = S_WORD;
        end
      end
      S_WORD:  if (accept && last_byte && last_word) state_next = S_CKSUM;
      S_CKSUM: if (accept) state_next = (in_data == xor_acc) ? S_DONE : S_ERROR;
      default: state_next = S_IDLE;
    endcase
  end

  assign active_next = (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                       (state_next == S_WORD)   || (state_next == S_CKSUM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      len          <= '0;
      xor_acc      <= '0;
      shift        <= '0;
      byte_idx     <= '0;
    end else begin
      state    <= state_next;
      // Status flags are registered copies of the next-state decode, so in_ready has no
      // combinational dependence on in_valid.
      in_ready <= active_next;
      busy     <= active_next;
      done     <= (state_next == S_DONE);
      err      <= (state_next == S_ERROR);
      cpu_hold <= (state_next != S_DONE);
      imem_we  <= 1'b0;

      if (imem_we) words_loaded <= words_loaded + (ADDR_W+1)'(1);

      if (can_start) begin
        words_loaded <= '0;
        xor_acc      <= '0;
        byte_idx     <= '0;
      end else if (accept) begin
        unique case (state)
          S_LEN_HI: begin
            len_hi  <= in_data;
            xor_acc <= xor_acc ^ in_data;
          end
          S_LEN_LO: begin
            len     <= len_rx;
            xor_acc <= xor_acc ^ in_data;
          end
          S_WORD: begin
            xor_acc  <= xor_acc ^ in_data;
            shift    <= {shift[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= words_loaded[ADDR_W-1:0];
              imem_wdata <= {shift, in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
